// File: rtl/arb3_pkg.sv
// Shared types and helpers for the 3-client arbiter lease guard.
package arb3_pkg;

  localparam int unsigned NCLIENT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REVOKE = 2'd2,
    COOL   = 2'd3
  } lease_state_e;

  function automatic logic is_onehot(input logic [NCLIENT-1:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [NCLIENT-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[1]) idx = 2'd1;
    if (v[2]) idx = 2'd2;
    return idx;
  endfunction

  function automatic logic [NCLIENT-1:0] idx_onehot(input logic [1:0] i);
    logic [NCLIENT-1:0] base;
    base = 3'b001;
    return base << i;
  endfunction

endpackage

// File: rtl/arb3_sat_cnt.sv
// Saturating up-counter with clear and load-one; used for tenure and grant statistics.
module arb3_sat_cnt #(
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         start,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] QMAX = W'(MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (start) begin
      q <= W'(1);
    end else if (inc && (q != QMAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/arb3_lease_guard.sv
// Lease/fairness guard around a 3-way mutex arbiter: times tenure, revokes and cools down holders.
// Optional per-client grant statistics when ARB3_LEASE_STATS_EN is defined.
module arb3_lease_guard
  import arb3_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned COOL_CYC = 4
`ifdef ARB3_LEASE_STATS_EN
  ,
  parameter int unsigned CNT_W    = 8
`endif
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NCLIENT-1:0]              req,
  input  logic [NCLIENT-1:0]              grant,
  output logic [NCLIENT-1:0]              req_gated,
  output logic [NCLIENT-1:0]              block,
  output logic [1:0]                      owner,
  output logic                            owner_vld,
  output logic [$clog2(MAX_HOLD+1)-1:0]   hold_cnt,
  output logic                            revoke,
  output logic                            err_multi
`ifdef ARB3_LEASE_STATS_EN
  ,
  output logic [NCLIENT*CNT_W-1:0]        grant_cnt
`endif
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam int unsigned CW = $clog2(COOL_CYC + 1);
  localparam logic [HW-1:0] HMAX    = HW'(MAX_HOLD);
  localparam logic [CW-1:0] COOL_LD = CW'(COOL_CYC);

  lease_state_e state, state_d;
  logic [CW-1:0]      cool_cnt, cool_d;
  logic [1:0]         owner_d, g_idx;
  logic               g_one, g_multi, same_owner;
  logic               trk_clr, trk_start, trk_inc, trk_exp;
  logic [HW-1:0]      hold_nxt;
  logic               do_trk, rev_fire, cool_done;
  logic               hold_clr, hold_start, hold_inc;
  logic [NCLIENT-1:0] block_d;
  logic               revoke_d, vld_d;

  assign g_one      = is_onehot(grant);
  assign g_multi    = (grant != '0) && !g_one;
  assign g_idx      = onehot_idx(grant);
  assign same_owner = g_one && (g_idx == owner) && (hold_cnt != '0);
  assign req_gated  = req & ~block;

  // Lease tracker shared by every state that follows the live grant.
  always_comb begin
    trk_clr   = 1'b0;
    trk_start = 1'b0;
    trk_inc   = 1'b0;
    hold_nxt  = '0;
    if (!g_one)          trk_clr   = 1'b1;
    else if (same_owner) trk_inc   = 1'b1;
    else                 trk_start = 1'b1;
    if (trk_start)    hold_nxt = HW'(1);
    else if (trk_inc) hold_nxt = (hold_cnt == HMAX) ? hold_cnt : hold_cnt + HW'(1);
    trk_exp = g_one && (hold_nxt == HMAX);
  end

  always_comb begin
    state_d   = state;
    cool_d    = cool_cnt;
    do_trk    = 1'b0;
    cool_done = 1'b0;
    if (g_multi) begin
      state_d = IDLE;
      cool_d  = '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          do_trk  = 1'b1;
          state_d = g_one ? HOLD : IDLE;
        end
        REVOKE: begin
          if (grant != idx_onehot(owner)) begin
            do_trk  = 1'b1;
            cool_d  = COOL_LD;
            state_d = COOL;
          end
        end
        COOL: begin
          do_trk = 1'b1;
          if (cool_cnt <= CW'(1)) begin
            cool_done = 1'b1;
            cool_d    = '0;
            state_d   = g_one ? HOLD : IDLE;
          end else begin
            cool_d = cool_cnt - CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
      // An expiring lease wins over every other transition, including a finishing cooldown.
      if (do_trk && trk_exp) state_d = REVOKE;
    end
  end

  assign rev_fire   = do_trk && trk_exp;
  assign hold_clr   = g_multi || (do_trk && trk_clr);
  assign hold_start = do_trk && trk_start;
  assign hold_inc   = do_trk && trk_inc;
  assign owner_d    = hold_start ? g_idx : owner;

  always_comb begin
    block_d  = block;
    revoke_d = 1'b0;
    if (g_multi) begin
      block_d = '0;
    end else if (rev_fire) begin
      block_d  = idx_onehot(owner_d);
      revoke_d = 1'b1;
    end else if (cool_done) begin
      block_d = '0;
    end
    vld_d = (state_d == HOLD) || (state_d == REVOKE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cool_cnt  <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
      block     <= '0;
      revoke    <= 1'b0;
      err_multi <= 1'b0;
    end else begin
      state     <= state_d;
      cool_cnt  <= cool_d;
      owner     <= owner_d;
      owner_vld <= vld_d;
      block     <= block_d;
      revoke    <= revoke_d;
      err_multi <= err_multi | g_multi;
    end
  end

  arb3_sat_cnt #(
    .W   (HW),
    .MAX (MAX_HOLD)
  ) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hold_clr),
    .start (hold_start),
    .inc   (hold_inc),
    .q     (hold_cnt)
  );

`ifdef ARB3_LEASE_STATS_EN
  logic [NCLIENT-1:0] grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) grant_q <= '0;
    else        grant_q <= grant;
  end

  for (genvar i = 0; i < NCLIENT; i++) begin : g_stat
    arb3_sat_cnt #(
      .W   (CNT_W),
      .MAX ((2 ** CNT_W) - 1)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .start (1'b0),
      .inc   (grant[i] & ~grant_q[i]),
      .q     (grant_cnt[i*CNT_W +: CNT_W])
    );
  end
`endif

endmodule

// File: tb/tb_arb3_lease_guard.sv
// Directed scoreboard bench for arb3_lease_guard, loop closed through a behavioural 3-way mutex arbiter.
module tb_arb3_lease_guard;

  logic       clk;
  logic       rst_n;
  logic [2:0] req, grant, arb_g, force_g;
  logic       force_en;
  logic [2:0] req_gated, block;
  logic [1:0] owner;
  logic       owner_vld, revoke, err_multi;
  logic [2:0] hold_cnt;
`ifdef ARB3_LEASE_STATS_EN
  logic [5:0] grant_cnt;
`endif

  logic [2:0] req1, g1, req_gated1, block1;
  logic [1:0] owner1;
  logic       owner_vld1, revoke1, err_multi1;
  logic [0:0] hold_cnt1;

  typedef struct {
    string       tag;
    int unsigned which;
    logic [13:0] v;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  arb3_lease_guard #(
    .MAX_HOLD (4),
    .COOL_CYC (2)
`ifdef ARB3_LEASE_STATS_EN
    ,
    .CNT_W    (2)
`endif
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .req_gated (req_gated),
    .block     (block),
    .owner     (owner),
    .owner_vld (owner_vld),
    .hold_cnt  (hold_cnt),
    .revoke    (revoke),
    .err_multi (err_multi)
`ifdef ARB3_LEASE_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  arb3_lease_guard #(
    .MAX_HOLD (1),
    .COOL_CYC (1)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req1),
    .grant     (g1),
    .req_gated (req_gated1),
    .block     (block1),
    .owner     (owner1),
    .owner_vld (owner_vld1),
    .hold_cnt  (hold_cnt1),
    .revoke    (revoke1),
    .err_multi (err_multi1)
`ifdef ARB3_LEASE_STATS_EN
    ,
    .grant_cnt ()
`endif
  );

  // Mutex arbiter: keeps the current holder while it still requests, else lowest index wins.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       arb_g <= 3'b000;
    else if ((arb_g & req_gated) != 3'b000) arb_g <= arb_g;
    else if (req_gated[0])            arb_g <= 3'b001;
    else if (req_gated[1])            arb_g <= 3'b010;
    else if (req_gated[2])            arb_g <= 3'b100;
    else                              arb_g <= 3'b000;
  end

  assign grant = force_en ? force_g : arb_g;

  function automatic logic [13:0] mk(input logic [2:0] rg, input logic [2:0] blk,
                                     input logic [1:0] own, input logic vld,
                                     input logic [2:0] hc, input logic rv, input logic er);
    return {rg, blk, own, vld, hc, rv, er};
  endfunction

  function logic [13:0] observe(input int unsigned which);
    logic [13:0] o;
    o = '0;
    if (which == 0)
      o = mk(req_gated, block, owner, owner_vld, hold_cnt, revoke, err_multi);
    else if (which == 1)
      o = mk(req_gated1, block1, owner1, owner_vld1, {2'b00, hold_cnt1}, revoke1, err_multi1);
`ifdef ARB3_LEASE_STATS_EN
    else
      o = {8'b0, grant_cnt};
`endif
    return o;
  endfunction

  task automatic check_now();
    exp_t        e;
    logic [13:0] o;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    e = sb.pop_front();
    o = observe(e.which);
    assert (o === e.v)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", e.tag, o, e.v);
    end
  endtask

  task automatic exp_now(input string tag, input int unsigned which, input logic [13:0] v);
    sb.push_back('{tag, which, v});
    check_now();
  endtask

  task automatic exp_next(input string tag, input int unsigned which, input logic [13:0] v);
    sb.push_back('{tag, which, v});
    @(negedge clk);
    check_now();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 3'b111; force_en = 1'b0; force_g = 3'b000;
    req1 = 3'b000; g1 = 3'b000;
    @(negedge clk);
    exp_now("reset_pass", 0, mk(3'b111, 3'b000, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0));
    exp_now("reset_dut1", 1, mk(3'b000, 3'b000, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0));

    // single client lease, revoke, cooldown, re-grant
    rst_n = 1'b1; req = 3'b010;
    exp_next("lease_k1",  0, mk(3'b010, 3'b000, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0));
    exp_next("lease_k2",  0, mk(3'b010, 3'b000, 2'd1, 1'b1, 3'd1, 1'b0, 1'b0));
    exp_next("lease_k3",  0, mk(3'b010, 3'b000, 2'd1, 1'b1, 3'd2, 1'b0, 1'b0));
    exp_next("lease_k4",  0, mk(3'b010, 3'b000, 2'd1, 1'b1, 3'd3, 1'b0, 1'b0));
    exp_next("lease_rev", 0, mk(3'b000, 3'b010, 2'd1, 1'b1, 3'd4, 1'b1, 1'b0));
    exp_next("lease_k6",  0, mk(3'b000, 3'b010, 2'd1, 1'b1, 3'd4, 1'b0, 1'b0));
    exp_next("cool_k7",   0, mk(3'b000, 3'b010, 2'd1, 1'b0, 3'd0, 1'b0, 1'b0));
    exp_next("cool_k8",   0, mk(3'b000, 3'b010, 2'd1, 1'b0, 3'd0, 1'b0, 1'b0));
    exp_next("unblk_k9",  0, mk(3'b010, 3'b000, 2'd1, 1'b0, 3'd0, 1'b0, 1'b0));
    exp_next("idle_k10",  0, mk(3'b010, 3'b000, 2'd1, 1'b0, 3'd0, 1'b0, 1'b0));
    exp_next("regrant",   0, mk(3'b010, 3'b000, 2'd1, 1'b1, 3'd1, 1'b0, 1'b0));
    req = 3'b000;
    exp_next("drop_k12",  0, mk(3'b000, 3'b000, 2'd1, 1'b1, 3'd2, 1'b0, 1'b0));
    exp_next("drop_idle", 0, mk(3'b000, 3'b000, 2'd1, 1'b0, 3'd0, 1'b0, 1'b0));

    // handover after revoke: client 0 takes over while client 1 cools down
    reset_pulse();
    req = 3'b010;
    exp_next("ho_k1",     0, mk(3'b010, 3'b000, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0));
    exp_next("ho_k2",     0, mk(3'b010, 3'b000, 2'd1, 1'b1, 3'd1, 1'b0, 1'b0));
    req = 3'b011;
    exp_next("ho_k3",     0, mk(3'b011, 3'b000, 2'd1, 1'b1, 3'd2, 1'b0, 1'b0));
    exp_next("ho_k4",     0, mk(3'b011, 3'b000, 2'd1, 1'b1, 3'd3, 1'b0, 1'b0));
    exp_next("ho_rev",    0, mk(3'b001, 3'b010, 2'd1, 1'b1, 3'd4, 1'b1, 1'b0));
    exp_next("ho_k6",     0, mk(3'b001, 3'b010, 2'd1, 1'b1, 3'd4, 1'b0, 1'b0));
    exp_next("ho_move",   0, mk(3'b001, 3'b010, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0));
    exp_next("ho_k8",     0, mk(3'b001, 3'b010, 2'd0, 1'b0, 3'd2, 1'b0, 1'b0));
    exp_next("ho_hold",   0, mk(3'b011, 3'b000, 2'd0, 1'b1, 3'd3, 1'b0, 1'b0));
    exp_next("ho_rev0",   0, mk(3'b010, 3'b001, 2'd0, 1'b1, 3'd4, 1'b1, 1'b0));
    exp_next("ho_k11",    0, mk(3'b010, 3'b001, 2'd0, 1'b1, 3'd4, 1'b0, 1'b0));
    exp_next("ho_back1",  0, mk(3'b010, 3'b001, 2'd1, 1'b0, 3'd1, 1'b0, 1'b0));

    // multi-hot grant forced onto the guard
    force_en = 1'b1; force_g = 3'b110;
    exp_next("multi_hot", 0, mk(3'b011, 3'b000, 2'd1, 1'b0, 3'd0, 1'b0, 1'b1));
    force_en = 1'b0;
    exp_next("multi_rec", 0, mk(3'b011, 3'b000, 2'd1, 1'b1, 3'd1, 1'b0, 1'b1));
    exp_next("multi_stk", 0, mk(3'b011, 3'b000, 2'd1, 1'b1, 3'd2, 1'b0, 1'b1));

    // asynchronous reset in the middle of a revoked lease
    reset_pulse();
    req = 3'b010;
    repeat (4) @(negedge clk);
    exp_next("ar_rev",    0, mk(3'b000, 3'b010, 2'd1, 1'b1, 3'd4, 1'b1, 1'b0));
    exp_next("ar_hold",   0, mk(3'b000, 3'b010, 2'd1, 1'b1, 3'd4, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    #1 exp_now("ar_async", 0, mk(3'b010, 3'b000, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0));
    exp_next("ar_norev",  0, mk(3'b010, 3'b000, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0));
    rst_n = 1'b1; req = 3'b000;
    @(negedge clk);

    // MAX_HOLD=1: expiry on first grant cycle, new revoke during cooldown releases old block
    req1 = 3'b100; g1 = 3'b100;
    exp_next("mh1_rev",   1, mk(3'b000, 3'b100, 2'd2, 1'b1, 3'd1, 1'b1, 1'b0));
    g1 = 3'b000;
    exp_next("mh1_cool",  1, mk(3'b000, 3'b100, 2'd2, 1'b0, 3'd0, 1'b0, 1'b0));
    g1 = 3'b001;
    exp_next("mh1_swap",  1, mk(3'b100, 3'b001, 2'd0, 1'b1, 3'd1, 1'b1, 1'b0));
    g1 = 3'b000;
    exp_next("mh1_cool0", 1, mk(3'b100, 3'b001, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0));
    exp_next("mh1_idle",  1, mk(3'b100, 3'b000, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0));

`ifdef ARB3_LEASE_STATS_EN
    reset_pulse();
    force_en = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      force_g = 3'b100;
      @(negedge clk);
      force_g = 3'b000;
      @(negedge clk);
      if (i == 2) exp_now("stats_3", 2, {8'b0, 2'd3, 2'd0, 2'd0});
    end
    exp_now("stats_sat", 2, {8'b0, 2'd3, 2'd0, 2'd0});
    force_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
